alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the main pipeline execute stage, port 1 is the multi-cycle/auxiliary unit.
- Each request carries the 6-bit ALU control code and two 32-bit operands. Requests use a valid/ready handshake.
- The block registers the winning request and drives the ALU from those registers.
- It captures out/zero/overflow and returns them on one shared response channel, tagged with the requester id. Response has valid/ready backpressure.

Parameters:
- DATA_W, 32, operand/result width
- CTRL_W, 6, ALU control code width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  2  per-requester request valid (bit i = port i)
- req_ready  out  2  per-requester accept; one-hot or zero
- req0_control  in  CTRL_W  port 0 ALU code
- req0_a  in  DATA_W  port 0 operand A (ALU read1)
- req0_b  in  DATA_W  port 0 operand B (ALU foutput)
- req1_control  in  CTRL_W  port 1 ALU code
- req1_a  in  DATA_W  port 1 operand A
- req1_b  in  DATA_W  port 1 operand B
- alu_control  out  CTRL_W  to ALU control
- alu_read1  out  DATA_W  to ALU read1
- alu_foutput  out  DATA_W  to ALU foutput
- alu_out  in  DATA_W  ALU result
- alu_zero  in  1  ALU branch-compare flag
- alu_overflow  in  1  ALU carry-out flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that owns the response
- rsp_result  out  DATA_W  captured alu_out
- rsp_zero  out  1  captured alu_zero
- rsp_overflow  out  1  captured alu_overflow
- rsp_err  out  1  control code unsupported

Behaviour:
- FSM states: IDLE, EXEC, RESP. On reset: state=IDLE, last_grant=1 (port 0 wins first tie), all rsp_* and alu_* registers=0.
- IDLE:
  - req_ready is nonzero only in IDLE. It is combinational from req_valid and last_grant.
  - Single valid request: that port is granted.
  - Both valid: grant the port != last_grant (round robin).
  - On grant, latch control/a/b into the operand registers, set id=granted port, last_grant=granted port, then go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_* outputs are driven from the operand registers. They are registered and stable from the cycle after grant until the next grant.
  - At the end of EXEC, capture alu_out/alu_zero/alu_overflow into rsp_* and go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* fields are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready, go to IDLE. rsp_valid drops the next cycle.
  - No new grant is possible in the same cycle as the response handshake.
- Latency: grant at cycle N, rsp_valid first high at N+2. Minimum issue interval is 3 cycles.
- Supported codes: 32, 8, 34, 14, 36, 12, 37, 13, 42, 10, 39, 4, 5.
  - Any other code is still issued and its result captured, with rsp_err=1.
- Branch codes 4/5: rsp_result is passed through as returned (0); only rsp_zero is meaningful.
- A requester holding req_valid without a grant must keep its fields stable. The arbiter does not sample ungranted ports.
- Reset asserted in any state: next cycle state=IDLE and all outputs at reset values. An in-flight request is dropped with no response.
- Starvation bound: a continuously valid port is granted within 2 grants.

Decomposition:
- Shared package alu_pkg:
  - Named localparams for every ALU code (ALU_ADD=32, ALU_ADDI=8, ALU_SUB=34, ALU_SUBI=14, ALU_AND=36, ALU_ANDI=12, ALU_OR=37, ALU_ORI=13, ALU_SLT=42, ALU_SLTI=10, ALU_NOR=39, ALU_BEQ=4, ALU_BNE=5).
  - State enum arb_state_t {IDLE, EXEC, RESP}.
  - Function is_supported(code).
- Sub-module rr_arb2: two-input round-robin grant (req[1:0], last, gnt[1:0]), purely combinational. All other logic stays in alu_arbiter.

Test Plan:
- Reset then port 0 issues code 32, a=5, b=7 -> req_ready=01 at N; alu_control=32 at N+1; rsp_valid at N+2 with result=12, zero=0, overflow=0, id=0, err=0.
- Both ports valid in the same cycle after reset (p0 code 36 a=0xF0F0 b=0xFF00, p1 code 37 a=1 b=2):
  - p0 granted first -> result 0xF000, id=0.
  - p1 granted next -> result 3, id=1.
- Port 1 code 32, a=0xFFFFFFFF, b=1 -> result=0, overflow=1. Port 0 code 4, a=b=0x1234 -> zero=1, result=0.
- rsp_ready held 0 for 3 cycles in RESP -> rsp_* constant, req_ready=00 despite req_valid=11. rsp_ready=1 -> IDLE next cycle, then grant goes to the port opposite the last response id.
- Port 0 code 63 -> rsp_err=1, id=0. Code 42 with a=-3, b=2 -> result=1, err=0.
- rst_n low during EXEC -> next cycle IDLE, rsp_valid=0, alu_*=0; no response ever appears for the dropped request.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU operation codes, arbiter FSM states
// and the supported-code check.
package alu_pkg;

    localparam int unsigned ALU_ADD  = 32;
    localparam int unsigned ALU_ADDI = 8;
    localparam int unsigned ALU_SUB  = 34;
    localparam int unsigned ALU_SUBI = 14;
    localparam int unsigned ALU_AND  = 36;
    localparam int unsigned ALU_ANDI = 12;
    localparam int unsigned ALU_OR   = 37;
    localparam int unsigned ALU_ORI  = 13;
    localparam int unsigned ALU_SLT  = 42;
    localparam int unsigned ALU_SLTI = 10;
    localparam int unsigned ALU_NOR  = 39;
    localparam int unsigned ALU_BEQ  = 4;
    localparam int unsigned ALU_BNE  = 5;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    function automatic logic is_supported(input int unsigned code);
        case (code)
            ALU_ADD, ALU_ADDI, ALU_SUB, ALU_SUBI, ALU_AND, ALU_ANDI, ALU_OR,
            ALU_ORI, ALU_SLT, ALU_SLTI, ALU_NOR, ALU_BEQ, ALU_BNE: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone request wins outright, a tie goes to the
// port that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// auxiliary unit (port 1); one request in flight, response tagged with its owner.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [CTRL_W-1:0] req0_control,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req1_control,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] alu_read1,
    output logic [DATA_W-1:0] alu_foutput,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_err
);

    arb_state_t state_q, state_d;
    logic       last_q;
    logic       id_q;
    logic [1:0] gnt;

    rr_arb2 u_rr (
        .req  (req_valid),
        .last (last_q),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt != '0) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE:    req_ready = gnt;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand registers feed the ALU directly, so alu_* hold from grant to next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            alu_control  <= '0;
            alu_read1    <= '0;
            alu_foutput  <= '0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            if (req_ready[0]) begin
                alu_control <= req0_control;
                alu_read1   <= req0_a;
                alu_foutput <= req0_b;
                id_q        <= 1'b0;
                last_q      <= 1'b0;
            end else if (req_ready[1]) begin
                alu_control <= req1_control;
                alu_read1   <= req1_a;
                alu_foutput <= req1_b;
                id_q        <= 1'b1;
                last_q      <= 1'b1;
            end
            if (state_q == EXEC) begin
                rsp_id       <= id_q;
                rsp_result   <= alu_out;
                rsp_zero     <= alu_zero;
                rsp_overflow <= alu_overflow;
                rsp_err      <= !is_supported(32'(alu_control));
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a transaction-level arbiter model
// checked every cycle, with directed scenarios and randomized traffic.
module tb_alu_arbiter;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [CTRL_W-1:0] req0_control, req1_control;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0] alu_read1, alu_foutput, alu_out;
    logic              alu_zero, alu_overflow;
    logic              rsp_valid, rsp_ready, rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero, rsp_overflow, rsp_err;

    int errors = 0;
    int checks = 0;

    int unsigned codes [13] = '{32, 8, 34, 14, 36, 12, 37, 13, 42, 10, 39, 4, 5};

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_control (req0_control),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_control (req1_control),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .alu_control  (alu_control),
        .alu_read1    (alu_read1),
        .alu_foutput  (alu_foutput),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err)
    );

    // Returns {overflow, zero, result}; unknown codes yield an arbitrary pattern.
    function automatic logic [33:0] alu_fn(input logic [5:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        z, v;
        s = '0;
        r = '0;
        v = 1'b0;
        case (c)
            6'd32, 6'd8:  begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; v = s[32]; end
            6'd34, 6'd14: r = a - b;
            6'd36, 6'd12: r = a & b;
            6'd37, 6'd13: r = a | b;
            6'd42, 6'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd39:        r = ~(a | b);
            6'd4, 6'd5:   r = '0;
            default:      r = a ^ b ^ 32'hDEAD_BEEF;
        endcase
        z = (c == 6'd4 || c == 6'd5) ? (a == b) : (r == 32'd0);
        return {v, z, r};
    endfunction

    function automatic logic supported(input logic [5:0] c);
        for (int i = 0; i < 13; i++)
            if (32'(c) == codes[i]) return 1'b1;
        return 1'b0;
    endfunction

    always_comb {alu_overflow, alu_zero, alu_out} = alu_fn(alu_control, alu_read1, alu_foutput);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one request in flight; response appears two cycles after grant.
    bit          m_known = 0;
    bit          m_busy  = 0;
    int          m_cnt   = 0;
    logic        m_last  = 1'b1;
    logic        m_id    = 1'b0;
    logic [5:0]  m_ctrl  = '0;
    logic [31:0] m_a     = '0;
    logic [31:0] m_b     = '0;
    logic [31:0] e_res   = '0;
    logic        e_z = 1'b0, e_v = 1'b0, e_id = 1'b0, e_err = 1'b0;

    always @(negedge clk) begin : model
        logic [1:0]  e_ready;
        logic [33:0] f;
        e_ready = 2'b00;
        if (m_known) begin
            if (!m_busy) begin
                if (req_valid == 2'b11) e_ready = m_last ? 2'b01 : 2'b10;
                else                    e_ready = req_valid;
            end
            chk("req_ready",    32'(req_ready),    32'(e_ready));
            chk("rsp_valid",    32'(rsp_valid),    32'(m_busy && m_cnt == 2));
            chk("alu_control",  32'(alu_control),  32'(m_ctrl));
            chk("alu_read1",    alu_read1,         m_a);
            chk("alu_foutput",  alu_foutput,       m_b);
            chk("rsp_id",       32'(rsp_id),       32'(e_id));
            chk("rsp_result",   rsp_result,        e_res);
            chk("rsp_zero",     32'(rsp_zero),     32'(e_z));
            chk("rsp_overflow", 32'(rsp_overflow), 32'(e_v));
            chk("rsp_err",      32'(rsp_err),      32'(e_err));
        end
        if (rst_n !== 1'b1) begin
            m_known = 1; m_busy = 0; m_cnt = 0; m_last = 1'b1; m_id = 1'b0;
            m_ctrl = '0; m_a = '0; m_b = '0;
            e_res = '0; e_z = 1'b0; e_v = 1'b0; e_id = 1'b0; e_err = 1'b0;
        end else if (m_known) begin
            if (m_busy && m_cnt == 1) begin
                f = alu_fn(m_ctrl, m_a, m_b);
                e_res = f[31:0]; e_z = f[32]; e_v = f[33];
                e_id = m_id; e_err = !supported(m_ctrl);
                m_cnt = 2;
            end else if (m_busy && m_cnt == 2) begin
                if (rsp_ready) m_busy = 0;
            end else if (!m_busy && e_ready != 2'b00) begin
                m_busy = 1; m_cnt = 1;
                m_id = e_ready[1]; m_last = m_id;
                m_ctrl = m_id ? req1_control : req0_control;
                m_a    = m_id ? req1_a : req0_a;
                m_b    = m_id ? req1_b : req0_b;
            end
        end
    end

    // Snapshot of one cycle's outputs; granted requesters drop valid afterwards.
    logic [1:0]  s_ready;
    logic        s_rv, s_id, s_z, s_v, s_err;
    logic [31:0] s_res;
    logic [5:0]  s_ctrl;

    task automatic cyc();
        @(negedge clk);
        s_ready = req_ready; s_rv = rsp_valid; s_id = rsp_id; s_res = rsp_result;
        s_z = rsp_zero; s_v = rsp_overflow; s_err = rsp_err; s_ctrl = alu_control;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~s_ready;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input string name);
        bit found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            if (s_rv) found = 1;
        end
        chk({name, "_timeout"}, 32'(found), 32'd1);
    endtask

    task automatic set_req(input int p, input logic [5:0] c, input logic [31:0] a,
                           input logic [31:0] b);
        if (p == 0) begin req0_control = c; req0_a = a; req0_b = b; end
        else        begin req1_control = c; req1_a = a; req1_b = b; end
        req_valid[p] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
        req0_control = '0; req0_a = '0; req0_b = '0;
        req1_control = '0; req1_a = '0; req1_b = '0;
        #1;
        do_reset();

        cyc();
        chk("reset_rsp_valid", 32'(s_rv), 32'd0);
        chk("reset_req_ready", 32'(s_ready), 32'd0);
        chk("reset_alu_ctrl",  32'(s_ctrl), 32'd0);
        chk("reset_result",    s_res, 32'd0);

        set_req(0, 6'd32, 32'd5, 32'd7);
        cyc();
        chk("add_grant", 32'(s_ready), 32'd1);
        cyc();
        chk("add_alu_ctrl", 32'(s_ctrl), 32'd32);
        chk("add_no_rsp_yet", 32'(s_rv), 32'd0);
        cyc();
        chk("add_rsp_valid", 32'(s_rv), 32'd1);
        chk("add_result", s_res, 32'd12);
        chk("add_flags", {29'd0, s_z, s_v, s_err}, 32'd0);
        chk("add_id", 32'(s_id), 32'd0);
        cyc();

        do_reset();
        set_req(0, 6'd36, 32'h0000_F0F0, 32'h0000_FF00);
        set_req(1, 6'd37, 32'd1, 32'd2);
        cyc();
        chk("tie_first_grant", 32'(s_ready), 32'd1);
        wait_rsp("and");
        chk("and_result", s_res, 32'h0000_F000);
        chk("and_id", 32'(s_id), 32'd0);
        wait_rsp("or");
        chk("or_result", s_res, 32'd3);
        chk("or_id", 32'(s_id), 32'd1);

        set_req(1, 6'd32, 32'hFFFF_FFFF, 32'd1);
        wait_rsp("carry");
        chk("carry_result", s_res, 32'd0);
        chk("carry_ovf", 32'(s_v), 32'd1);
        chk("carry_id", 32'(s_id), 32'd1);
        set_req(0, 6'd4, 32'h1234, 32'h1234);
        wait_rsp("beq");
        chk("beq_zero", 32'(s_z), 32'd1);
        chk("beq_result", s_res, 32'd0);

        rsp_ready = 1'b0;
        set_req(0, 6'd37, 32'h10, 32'h01);
        wait_rsp("bp");
        set_req(0, 6'd32, 32'd1, 32'd1);
        set_req(1, 6'd34, 32'd9, 32'd4);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_valid", 32'(s_rv), 32'd1);
            chk("bp_hold_result", s_res, 32'h11);
            chk("bp_hold_id", 32'(s_id), 32'd0);
            chk("bp_no_grant", 32'(s_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cyc();
        cyc();
        chk("bp_after_grant", 32'(s_ready), 32'd2);
        wait_rsp("bp_sub");
        chk("bp_sub_result", s_res, 32'd5);
        chk("bp_sub_id", 32'(s_id), 32'd1);
        wait_rsp("bp_add");
        chk("bp_add_result", s_res, 32'd2);
        chk("bp_add_id", 32'(s_id), 32'd0);

        set_req(0, 6'd63, 32'd1, 32'd2);
        wait_rsp("bad");
        chk("bad_err", 32'(s_err), 32'd1);
        chk("bad_id", 32'(s_id), 32'd0);
        set_req(0, 6'd42, 32'hFFFF_FFFD, 32'd2);
        wait_rsp("slt");
        chk("slt_result", s_res, 32'd1);
        chk("slt_err", 32'(s_err), 32'd0);

        set_req(0, 6'd32, 32'd2, 32'd3);
        cyc();
        chk("drop_grant", 32'(s_ready), 32'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("drop_rsp_valid", 32'(s_rv), 32'd0);
        chk("drop_alu_ctrl", 32'(s_ctrl), 32'd0);
        chk("drop_result", s_res, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("drop_no_rsp", 32'(s_rv), 32'd0);
        end

        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(2) == 0) begin
                    set_req(p,
                            ($urandom_range(7) == 0) ? 6'($urandom) : 6'(codes[$urandom_range(12)]),
                            $urandom_range(1) ? 32'($urandom) : 32'($urandom_range(15)),
                            $urandom_range(1) ? 32'($urandom) : 32'($urandom_range(15)));
                end
            end
            rsp_ready = ($urandom_range(9) < 7);
            rst_n = ($urandom_range(149) != 0);
            cyc();
        end

        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        repeat (4) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
